// File: rtl/pc_gen_if.sv
// Fetch-PC generator bus: pipeline control inputs, BTB training and the fetch PC/prediction.
// The master drives control and training; the slave (pc_gen) returns the PC and its prediction.
interface pc_gen_if #(
   parameter int unsigned XLEN = 32
);
   logic            stall_i;
   logic            trap_i;
   logic [XLEN-1:0] trap_vec_i;
   logic            mret_i;
   logic [XLEN-1:0] mepc_i;
   logic            redirect_i;
   logic [XLEN-1:0] redirect_pc_i;
   logic            upd_valid_i;
   logic [XLEN-1:0] upd_pc_i;
   logic [XLEN-1:0] upd_target_i;
   logic            upd_taken_i;
   logic [XLEN-1:0] pc_o;
   logic            pred_taken_o;
   logic [XLEN-1:0] pred_target_o;

   modport master (
      output stall_i, trap_i, trap_vec_i, mret_i, mepc_i, redirect_i, redirect_pc_i,
      output upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i,
      input  pc_o, pred_taken_o, pred_target_o
   );

   modport slave (
      input  stall_i, trap_i, trap_vec_i, mret_i, mepc_i, redirect_i, redirect_pc_i,
      input  upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i,
      output pc_o, pred_taken_o, pred_target_o
   );
endinterface

// File: rtl/pc_gen.sv
// Fetch-stage PC generator with a direct-mapped BTB of 2-bit saturating counters.
// Next PC priority: trap, mret, redirect, stall, BTB prediction, PC+4.
module pc_gen #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int unsigned     BTB_ENTRIES  = 16
) (
   input logic     clk,
   input logic     rst,
   pc_gen_if.slave bus
);
   localparam int unsigned IDX  = $clog2(BTB_ENTRIES);
   localparam int unsigned TAGW = XLEN - IDX - 2;

   // PCs and targets are word aligned, so only bits [XLEN-1:2] are stored.
   logic [XLEN-1:2]  pc_q, pc_d;
   logic [BTB_ENTRIES-1:0] valid_q;
   logic [TAGW-1:0]  tag_q [BTB_ENTRIES];
   logic [XLEN-1:2]  tgt_q [BTB_ENTRIES];
   logic [1:0]       ctr_q [BTB_ENTRIES];

   logic [IDX-1:0]   rd_idx, wr_idx;
   logic [TAGW-1:0]  rd_tag, wr_tag;
   logic             rd_hit, wr_hit;
   logic             pred_taken;
   logic [XLEN-1:2]  pc_plus4, pred_tgt;
   logic [1:0]       ctr_inc, ctr_dec;

   logic unused_lsbs;
   assign unused_lsbs = ^{bus.trap_vec_i[1:0], bus.mepc_i[1:0], bus.redirect_pc_i[1:0],
                          bus.upd_pc_i[1:0], bus.upd_target_i[1:0], RESET_VECTOR[1:0]};

   // Lookup on the current fetch PC
   always_comb begin
      rd_idx     = pc_q[IDX+1:2];
      rd_tag     = pc_q[XLEN-1:IDX+2];
      rd_hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
      pred_taken = rd_hit && ctr_q[rd_idx][1];
      pc_plus4   = pc_q + 1'b1;
      pred_tgt   = rd_hit ? tgt_q[rd_idx] : pc_plus4;
   end

   assign bus.pc_o          = {pc_q, 2'b00};
   assign bus.pred_taken_o  = pred_taken;
   assign bus.pred_target_o = {pred_tgt, 2'b00};

   always_comb begin
      pc_d = pc_plus4;
      if (bus.trap_i) begin
         pc_d = bus.trap_vec_i[XLEN-1:2];
      end else if (bus.mret_i) begin
         pc_d = bus.mepc_i[XLEN-1:2];
      end else if (bus.redirect_i) begin
         pc_d = bus.redirect_pc_i[XLEN-1:2];
      end else if (bus.stall_i) begin
         pc_d = pc_q;
      end else if (pred_taken) begin
         pc_d = pred_tgt;
      end
   end

   // Training lookup on the resolved branch PC
   always_comb begin
      wr_idx  = bus.upd_pc_i[IDX+1:2];
      wr_tag  = bus.upd_pc_i[XLEN-1:IDX+2];
      wr_hit  = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
      ctr_inc = (ctr_q[wr_idx] == 2'b11) ? 2'b11 : ctr_q[wr_idx] + 2'd1;
      ctr_dec = (ctr_q[wr_idx] == 2'b00) ? 2'b00 : ctr_q[wr_idx] - 2'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q    <= RESET_VECTOR[XLEN-1:2];
         valid_q <= '0;
      end else begin
         pc_q <= pc_d;
         if (bus.upd_valid_i && bus.upd_taken_i && !wr_hit) begin
            valid_q[wr_idx] <= 1'b1;
         end
      end
   end

   // Entry payload needs no reset: it is only observed through a valid bit.
   always_ff @(posedge clk) begin
      if (rst && bus.upd_valid_i) begin
         if (wr_hit) begin
            if (bus.upd_taken_i) begin
               ctr_q[wr_idx] <= ctr_inc;
               tgt_q[wr_idx] <= bus.upd_target_i[XLEN-1:2];
            end else begin
               ctr_q[wr_idx] <= ctr_dec;
            end
         end else if (bus.upd_taken_i) begin
            tag_q[wr_idx] <= wr_tag;
            tgt_q[wr_idx] <= bus.upd_target_i[XLEN-1:2];
            ctr_q[wr_idx] <= 2'b10;
         end
      end
   end
endmodule
